// File: rtl/seven_segment_decoder_if.sv
// Digit-to-display bus between the digit/counter logic and the segment decoder.
//   binary_input   : 4-bit BCD digit (valid codes 0-9)
//   blank          : forces all segments off when 1
//   segment_output : 7-bit segment drive, bit order {g,f,e,d,c,b,a}
//   invalid        : flag for a non-BCD code (10-15) sampled while not blanked
// master = digit source, slave = decoder.
interface seven_segment_decoder_if;
  localparam int unsigned DIG_W = 4;
  localparam int unsigned SEG_W = 7;

  logic [DIG_W-1:0] binary_input;
  logic             blank;
  logic [SEG_W-1:0] segment_output;
  logic             invalid;

  modport master (
    output binary_input,
    output blank,
    input  segment_output,
    input  invalid
  );

  modport slave (
    input  binary_input,
    input  blank,
    output segment_output,
    output invalid
  );
endinterface

// File: rtl/seven_segment_decoder.sv
// Registered BCD-to-seven-segment decoder for one display digit.
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset (outputs all-off, invalid = 0)
//   bus   : seven_segment_decoder_if.slave (binary_input, blank in;
//           segment_output, invalid out). Outputs are registered, one-cycle latency.
// Parameter:
//   ACTIVE_LOW : 1 inverts all seven segment bits (common-anode); invalid unaffected.
module seven_segment_decoder #(
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  seven_segment_decoder_if.slave  bus
);
  localparam int unsigned DIG_W = 4;
  localparam int unsigned SEG_W = 7;

  // XOR mask applied to the active-high pattern; also the all-off value.
  localparam logic [SEG_W-1:0] SEG_POL = ACTIVE_LOW ? {SEG_W{1'b1}} : {SEG_W{1'b0}};

  logic [DIG_W-1:0] w_digit;
  logic [SEG_W-1:0] w_pattern;
  logic             w_code_invalid;
  logic [SEG_W-1:0] w_seg_next;
  logic             w_invalid_next;

  logic [SEG_W-1:0] r_segment;
  logic             r_invalid;

  assign w_digit = bus.binary_input;

  // Active-high decode of the digit; non-BCD codes yield a dark pattern.
  always_comb begin
    w_pattern      = '0;
    w_code_invalid = 1'b0;
    case (w_digit)
      4'd0:    w_pattern = 7'h3F;
      4'd1:    w_pattern = 7'h06;
      4'd2:    w_pattern = 7'h5B;
      4'd3:    w_pattern = 7'h4F;
      4'd4:    w_pattern = 7'h66;
      4'd5:    w_pattern = 7'h6D;
      4'd6:    w_pattern = 7'h7D;
      4'd7:    w_pattern = 7'h07;
      4'd8:    w_pattern = 7'h7F;
      4'd9:    w_pattern = 7'h6F;
      default: begin
        w_pattern      = 7'h00;
        w_code_invalid = 1'b1;
      end
    endcase
  end

  // Blank overrides both the pattern and the invalid flag; polarity applied last.
  always_comb begin
    w_seg_next     = (bus.blank ? {SEG_W{1'b0}} : w_pattern) ^ SEG_POL;
    w_invalid_next = ~bus.blank & w_code_invalid;
  end

  // Output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_segment <= SEG_POL;
      r_invalid <= 1'b0;
    end else begin
      r_segment <= w_seg_next;
      r_invalid <= w_invalid_next;
    end
  end

  assign bus.segment_output = r_segment;
  assign bus.invalid        = r_invalid;
endmodule

// File: tb/tb_seven_segment_decoder.sv
// Self-checking bench: drives an ACTIVE_LOW=0 and an ACTIVE_LOW=1 decoder in
// lockstep and compares both against a scoreboard of expected outputs.
module tb_seven_segment_decoder;
  logic clk;
  logic rst_n;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [6:0] seg_hi;  // ACTIVE_LOW=0 build
    logic [6:0] seg_lo;  // ACTIVE_LOW=1 build
    logic       inv;
    string      tag;
  } exp_t;

  exp_t sb[$];

  logic [6:0] lut [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                           7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  seven_segment_decoder_if bus_hi ();
  seven_segment_decoder_if bus_lo ();

  seven_segment_decoder #(.ACTIVE_LOW(1'b0)) u_dut_hi (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_hi.slave)
  );

  seven_segment_decoder #(.ACTIVE_LOW(1'b1)) u_dut_lo (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_lo.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  task automatic check7(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Drive one input, push its expected result, clock once, pop and compare.
  task automatic step(input logic [3:0] d, input logic b, input string tag);
    exp_t e;
    exp_t got;
    logic [6:0] v;
    v = 7'h00;
    if (!b && d < 4'd10) v = lut[d];
    e.seg_hi = v;
    e.seg_lo = ~v;
    e.inv    = !b && (d >= 4'd10);
    e.tag    = tag;
    bus_hi.binary_input = d;
    bus_hi.blank        = b;
    bus_lo.binary_input = d;
    bus_lo.blank        = b;
    sb.push_back(e);
    @(posedge clk);
    #1;
    checks++;
    assert (sb.size() > 0) else begin
      failures++;
      $error("FAIL %s_sb observed=empty expected=entry", tag);
    end
    if (sb.size() > 0) begin
      got = sb.pop_front();
      check7({got.tag, "_seg_hi"}, bus_hi.segment_output, got.seg_hi);
      check7({got.tag, "_seg_lo"}, bus_lo.segment_output, got.seg_lo);
      check1({got.tag, "_inv_hi"}, bus_hi.invalid, got.inv);
      check1({got.tag, "_inv_lo"}, bus_lo.invalid, got.inv);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    bus_hi.binary_input = 4'd8;
    bus_hi.blank        = 1'b0;
    bus_lo.binary_input = 4'd8;
    bus_lo.blank        = 1'b0;

    // Reset held across clock edges with a valid digit present.
    repeat (3) @(posedge clk);
    #1;
    check7("reset_seg_hi", bus_hi.segment_output, 7'h00);
    check7("reset_seg_lo", bus_lo.segment_output, 7'h7F);
    check1("reset_inv_hi", bus_hi.invalid, 1'b0);
    check1("reset_inv_lo", bus_lo.invalid, 1'b0);
    #2;
    rst_n = 1'b1;
    step(4'd8, 1'b0, "post_reset_8");

    // Sweep of all valid digits, one per cycle.
    for (int i = 0; i < 10; i++) step(4'(i), 1'b0, $sformatf("sweep_%0d", i));

    // Invalid codes, then recovery to a valid digit.
    step(4'hA, 1'b0, "invalid_A");
    step(4'hF, 1'b0, "invalid_F");
    step(4'd3, 1'b0, "recover_3");

    // Blank takes priority over both valid and invalid codes.
    step(4'd5, 1'b1, "blank_5");
    step(4'hC, 1'b1, "blank_C");
    step(4'd5, 1'b0, "unblank_5");

    // Asynchronous reset between edges while showing digit 6.
    step(4'd6, 1'b0, "show_6");
    #2;
    rst_n = 1'b0;
    #1;
    check7("async_rst_seg_hi", bus_hi.segment_output, 7'h00);
    check7("async_rst_seg_lo", bus_lo.segment_output, 7'h7F);
    check1("async_rst_inv_hi", bus_hi.invalid, 1'b0);
    #1;
    rst_n = 1'b1;
    step(4'd0, 1'b0, "resume_0");
    step(4'hB, 1'b0, "resume_invalid_B");

    // Short random tail of mixed codes and blanking.
    for (int i = 0; i < 20; i++)
      step(4'($urandom_range(0, 15)), 1'($urandom_range(0, 3) == 0), $sformatf("rand_%0d", i));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
